trigger_ctrl: RTL and testbench
===============================

TRIGGER_CTRL -- requirements
Module: trigger_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample and trigger-pattern width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, capture-buffer address width (buffer depth 2**ADDR_WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port arm  input  1  single-cycle request to start a capture.
REQ-006 SHALL have port abort  input  1  cancels capture and returns to IDLE.
REQ-007 SHALL have port sample_in  input  DATA_WIDTH  probed signals, one sample per clk.
REQ-008 SHALL have port trig_mask  input  DATA_WIDTH  1 = bit participates in trigger compare.
REQ-009 SHALL have port trig_value  input  DATA_WIDTH  required value of masked bits.
REQ-010 SHALL have port trig_edge  input  1  0 = level trigger, 1 = match-rising-edge trigger.
REQ-011 SHALL have port post_count  input  ADDR_WIDTH  samples to store after the trigger sample.
REQ-012 SHALL have port waddr  input  ADDR_WIDTH  current write address from the buffer-write stage.
REQ-013 SHALL have port primed  input  1  buffer-write stage has wrapped its address once.
REQ-014 SHALL have port write_enable  output  1  write strobe to the buffer-write stage.
REQ-015 SHALL have port data  output  DATA_WIDTH  sample to the buffer-write stage.
REQ-016 SHALL have port triggered  output  1  trigger has fired in this capture.
REQ-017 SHALL have port trig_addr  output  ADDR_WIDTH  buffer address holding the trigger sample.
REQ-018 SHALL have port done  output  1  capture complete, buffer frozen.
REQ-019 SHALL have port state  output  3  encoded FSM state for debug.

Function
REQ-020 SHALL implement states IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4 in one registered state variable driven onto state.
REQ-021 SHALL drive data = sample_in combinationally, so the sample presented in a cycle is the one written that cycle.
REQ-022 SHALL decode write_enable from the state register only: 1 in FILL, ARMED, POST; 0 in IDLE, DONE.
REQ-023 SHALL compute match = (((sample_in ^ trig_value) & trig_mask) == 0); all-zero trig_mask matches every sample.
REQ-024 SHALL register match into match_d every cycle in every state.
REQ-025 SHALL define fire = match when trig_edge=0, and match & !match_d when trig_edge=1.
REQ-026 IDLE: arm=1 -> FILL; triggered, done and trig_addr cleared on the same edge.
REQ-027 FILL: primed=1 -> ARMED; fire ignored in FILL (no pre-trigger history yet).
REQ-028 ARMED: fire=1 -> triggered<=1, trig_addr<=waddr, post counter<=post_count; next state POST when post_count!=0, DONE when post_count==0.
REQ-029 POST: counter decrements by 1 per cycle; when counter==1 the state goes to DONE on that edge; exactly post_count samples written after the trigger sample.
REQ-030 DONE: done=1, write_enable=0, triggered and trig_addr held; arm=1 -> FILL with triggered/done/trig_addr cleared.
REQ-031 SHALL ignore arm in FILL, ARMED and POST.
REQ-032 abort=1 in any state -> IDLE next edge, triggered/done cleared, trig_addr held; abort wins over arm and fire in the same cycle.
REQ-033 Re-arm with primed already 1 SHALL spend exactly one cycle in FILL before ARMED.
REQ-034 post_count SHALL be sampled only on the fire cycle; later changes do not affect the running capture.
REQ-035 Counter arithmetic SHALL be ADDR_WIDTH bits, unsigned, and never underflow.

Reset
REQ-036 reset=0 SHALL immediately force state=IDLE, triggered=0, done=0, trig_addr=0, counter=0, match_d=0, hence write_enable=0, regardless of clk.
REQ-037 Reset asserted mid-capture SHALL discard the capture; after release the block waits in IDLE for arm.

Verification
REQ-038 Level: ADDR_WIDTH=4, mask=0xFF, value=0x5A, edge=0, post_count=3, arm, primed rises, 0x5A at waddr=9 -> trig_addr=9, write_enable high for exactly 3 more cycles, done=1, state=4.
REQ-039 Edge: edge=1, sample_in already 0x5A when entering ARMED -> no fire until sample leaves and returns to 0x5A; trig_addr = waddr of the return cycle.
REQ-040 post_count=0: fire at waddr=2 -> next state DONE directly, trig_addr=2, only the trigger sample written after ARMED.
REQ-041 FILL gating: trigger pattern present while primed=0 -> triggered stays 0; fires only after ARMED is entered.
REQ-042 Abort and arm together in POST -> IDLE next cycle, write_enable=0, done=0, triggered=0.
REQ-043 Async reset pulse mid-POST between clk edges -> outputs at reset values immediately; arm after release -> FILL.

Source files
------------

// File: rtl/trigger_ctrl.sv
// Logic-analyser trigger controller: sequences fill, trigger wait and post-trigger
// capture for an external circular buffer-write stage.
module trigger_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic                  trig_edge,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  primed,
    output logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  triggered,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  done,
    output logic [2:0]            state
);

    // state | meaning
    // IDLE  | waiting for arm, buffer not written
    // FILL  | writing until the buffer has wrapped once (pre-trigger history)
    // ARMED | writing, watching for the trigger condition
    // POST  | writing the remaining post-trigger samples
    // DONE  | capture complete, buffer frozen
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                cur_state, nxt_state;
    logic                  trig_nxt;
    logic [ADDR_WIDTH-1:0] trig_addr_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  match, match_d, fire;

    assign match = (((sample_in ^ trig_value) & trig_mask) == '0);
    assign fire  = trig_edge ? (match & ~match_d) : match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= IDLE;
            triggered <= 1'b0;
            trig_addr <= '0;
            cnt       <= '0;
            match_d   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            triggered <= trig_nxt;
            trig_addr <= trig_addr_nxt;
            cnt       <= cnt_nxt;
            match_d   <= match;
        end
    end

    always_comb begin
        nxt_state     = cur_state;
        trig_nxt      = triggered;
        trig_addr_nxt = trig_addr;
        cnt_nxt       = cnt;
        if (abort) begin
            nxt_state = IDLE;
            trig_nxt  = 1'b0;
        end else begin
            case (cur_state)
                IDLE, DONE: begin
                    if (arm) begin
                        nxt_state     = FILL;
                        trig_nxt      = 1'b0;
                        trig_addr_nxt = '0;
                    end
                end
                FILL: begin
                    if (primed) nxt_state = ARMED;
                end
                ARMED: begin
                    if (fire) begin
                        trig_nxt      = 1'b1;
                        trig_addr_nxt = waddr;
                        cnt_nxt       = post_count;
                        nxt_state     = (post_count == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    // a zero count cannot occur here, but it must not wrap if it did
                    if (cnt != '0) cnt_nxt = cnt - 1'b1;
                    if (cnt <= 1) nxt_state = DONE;
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    assign data         = sample_in;
    assign write_enable = (cur_state == FILL) || (cur_state == ARMED) || (cur_state == POST);
    assign done         = (cur_state == DONE);
    assign state        = cur_state;

endmodule

// File: tb/tb_trigger_ctrl.sv
// Self-checking bench for trigger_ctrl: directed scenarios plus randomized captures
// predicted from the sample stream by a scan-based reference model.
module tb_trigger_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic [7:0] trig_mask = 8'hFF;
    logic [7:0] trig_value = 8'h5A;
    logic       trig_edge = 1'b0;
    logic [3:0] post_count = 4'd0;
    logic [3:0] waddr = 4'd0;
    logic       primed = 1'b0;
    logic       write_enable;
    logic [7:0] data;
    logic       triggered;
    logic [3:0] trig_addr;
    logic       done;
    logic [2:0] state;

    int n_checks = 0;
    int n_fails  = 0;

    trigger_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .sample_in(sample_in),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .post_count(post_count), .waddr(waddr), .primed(primed),
        .write_enable(write_enable), .data(data), .triggered(triggered),
        .trig_addr(trig_addr), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // advance one clock; inputs are changed and registered outputs sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic spec_match(input logic [7:0] s);
        return ((s ^ trig_value) & trig_mask) == 8'd0;
    endfunction

    task automatic test_reset();
        #3;
        n_checks++; if (state !== 3'd0) begin n_fails++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_checks++; if (write_enable !== 1'b0) begin n_fails++; $display("FAIL reset_we got=%b exp=0", write_enable); end
        n_checks++; if (triggered !== 1'b0 || done !== 1'b0) begin n_fails++; $display("FAIL reset_flags got=%b%b exp=00", triggered, done); end
        n_checks++; if (trig_addr !== 4'd0) begin n_fails++; $display("FAIL reset_addr got=%0d exp=0", trig_addr); end
        sample_in = 8'hA5;
        #1;
        n_checks++; if (data !== 8'hA5) begin n_fails++; $display("FAIL data_pass got=%h exp=a5", data); end
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        n_checks++; if (state !== 3'd0 || write_enable !== 1'b0) begin n_fails++; $display("FAIL idle_wait got=%0d/%b exp=0/0", state, write_enable); end
    endtask

    task automatic test_level();
        int wcnt;
        trig_mask = 8'hFF; trig_value = 8'h5A; trig_edge = 1'b0; post_count = 4'd3;
        arm = 1'b1; sample_in = 8'h00;
        cyc();
        arm = 1'b0;
        n_checks++; if (state !== 3'd1 || write_enable !== 1'b1) begin n_fails++; $display("FAIL lvl_fill got=%0d/%b exp=1/1", state, write_enable); end
        sample_in = 8'h5A;
        repeat (3) cyc();
        n_checks++; if (triggered !== 1'b0 || state !== 3'd1) begin n_fails++; $display("FAIL fill_gate got=%b/%0d exp=0/1", triggered, state); end
        primed = 1'b1;
        cyc();
        n_checks++; if (state !== 3'd2) begin n_fails++; $display("FAIL lvl_armed got=%0d exp=2", state); end
        sample_in = 8'h11; waddr = 4'd8;
        cyc();
        n_checks++; if (triggered !== 1'b0 || state !== 3'd2) begin n_fails++; $display("FAIL lvl_nofire got=%b/%0d exp=0/2", triggered, state); end
        sample_in = 8'h5A; waddr = 4'd9;
        cyc();
        n_checks++; if (triggered !== 1'b1 || trig_addr !== 4'd9 || state !== 3'd3) begin n_fails++; $display("FAIL lvl_fire got=%b/%0d/%0d exp=1/9/3", triggered, trig_addr, state); end
        post_count = 4'd7; sample_in = 8'h00;
        wcnt = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (write_enable) wcnt++;
            cyc();
        end
        n_checks++; if (wcnt != 3) begin n_fails++; $display("FAIL lvl_post_cnt got=%0d exp=3", wcnt); end
        n_checks++; if (done !== 1'b1 || state !== 3'd4 || write_enable !== 1'b0 || trig_addr !== 4'd9) begin n_fails++; $display("FAIL lvl_done got=%b/%0d/%b/%0d exp=1/4/0/9", done, state, write_enable, trig_addr); end
    endtask

    task automatic test_edge_and_zero();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        n_checks++; if (state !== 3'd0 || triggered !== 1'b0 || done !== 1'b0 || trig_addr !== 4'd9) begin n_fails++; $display("FAIL abort_hold got=%0d/%b/%b/%0d exp=0/0/0/9", state, triggered, done, trig_addr); end
        trig_edge = 1'b1; post_count = 4'd1; sample_in = 8'h5A; arm = 1'b1;
        cyc();
        arm = 1'b0;
        n_checks++; if (state !== 3'd1) begin n_fails++; $display("FAIL edge_fill got=%0d exp=1", state); end
        cyc();
        n_checks++; if (state !== 3'd2) begin n_fails++; $display("FAIL one_cycle_fill got=%0d exp=2", state); end
        waddr = 4'd3; cyc();
        waddr = 4'd4; cyc();
        n_checks++; if (triggered !== 1'b0) begin n_fails++; $display("FAIL edge_held_level got=%b exp=0", triggered); end
        sample_in = 8'h00; waddr = 4'd5; cyc();
        sample_in = 8'h5A; waddr = 4'd6; cyc();
        n_checks++; if (triggered !== 1'b1 || trig_addr !== 4'd6 || state !== 3'd3) begin n_fails++; $display("FAIL edge_fire got=%b/%0d/%0d exp=1/6/3", triggered, trig_addr, state); end
        cyc();
        n_checks++; if (state !== 3'd4 || done !== 1'b1) begin n_fails++; $display("FAIL edge_done got=%0d/%b exp=4/1", state, done); end
        arm = 1'b1; trig_edge = 1'b0; post_count = 4'd0; sample_in = 8'h00;
        cyc();
        arm = 1'b0;
        n_checks++; if (state !== 3'd1 || triggered !== 1'b0 || done !== 1'b0 || trig_addr !== 4'd0) begin n_fails++; $display("FAIL rearm_clear got=%0d/%b/%b/%0d exp=1/0/0/0", state, triggered, done, trig_addr); end
        cyc();
        sample_in = 8'h5A; waddr = 4'd2;
        cyc();
        n_checks++; if (state !== 3'd4 || triggered !== 1'b1 || trig_addr !== 4'd2 || write_enable !== 1'b0) begin n_fails++; $display("FAIL pc0_done got=%0d/%b/%0d/%b exp=4/1/2/0", state, triggered, trig_addr, write_enable); end
    endtask

    task automatic test_abort_arm();
        post_count = 4'd5; arm = 1'b1;
        cyc();
        arm = 1'b0;
        cyc();
        sample_in = 8'h5A;
        cyc();
        n_checks++; if (state !== 3'd3) begin n_fails++; $display("FAIL abort_setup got=%0d exp=3", state); end
        abort = 1'b1; arm = 1'b1;
        cyc();
        abort = 1'b0; arm = 1'b0;
        n_checks++; if (state !== 3'd0 || write_enable !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin n_fails++; $display("FAIL abort_wins got=%0d/%b/%b/%b exp=0/0/0/0", state, write_enable, done, triggered); end
    endtask

    task automatic test_async_reset();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        cyc();
        cyc();
        n_checks++; if (state !== 3'd3) begin n_fails++; $display("FAIL rst_setup got=%0d exp=3", state); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (state !== 3'd0 || write_enable !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 || trig_addr !== 4'd0) begin n_fails++; $display("FAIL async_rst got=%0d/%b/%b/%b/%0d exp=0/0/0/0/0", state, write_enable, triggered, done, trig_addr); end
        #1 reset = 1'b1;
        cyc();
        n_checks++; if (state !== 3'd0) begin n_fails++; $display("FAIL rst_idle got=%0d exp=0", state); end
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        n_checks++; if (state !== 3'd1) begin n_fails++; $display("FAIL rst_rearm got=%0d exp=1", state); end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    // Reference: the trigger is the first ARMED-phase sample whose masked compare holds
    // (and, for edge mode, whose predecessor's did not); it is followed by exactly
    // post_count written samples taken from the value latched at that moment.
    task automatic test_random();
        logic       in_fill = 1'b0;
        logic       prev, fire_exp, fired;
        logic [3:0] pc, exp_addr;
        int         wcnt;
        for (int it = 0; it < 40; it++) begin
            if (!in_fill) begin
                arm = 1'b1; sample_in = 8'($urandom);
                cyc();
                arm = 1'b0;
            end
            n_checks++; if (state !== 3'd1 || triggered !== 1'b0 || done !== 1'b0 || trig_addr !== 4'd0) begin n_fails++; $display("FAIL rnd_fill it=%0d got=%0d/%b/%b/%0d exp=1/0/0/0", it, state, triggered, done, trig_addr); end
            trig_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            trig_value = 8'($urandom);
            trig_edge  = 1'($urandom);
            pc         = 4'($urandom_range(0, 15));
            post_count = pc;
            primed     = 1'b0;
            for (int f = $urandom_range(0, 3); f > 0; f--) begin
                sample_in = ($urandom_range(0, 2) == 0) ? trig_value : 8'($urandom);
                cyc();
            end
            n_checks++; if (triggered !== 1'b0 || state !== 3'd1) begin n_fails++; $display("FAIL rnd_gate it=%0d got=%b/%0d exp=0/1", it, triggered, state); end
            primed = 1'b1;
            sample_in = ($urandom_range(0, 2) == 0) ? trig_value : 8'($urandom);
            prev = spec_match(sample_in);
            cyc();
            n_checks++; if (state !== 3'd2) begin n_fails++; $display("FAIL rnd_armed it=%0d got=%0d exp=2", it, state); end
            fired = 1'b0;
            exp_addr = 4'd0;
            for (int k = 0; k < 12 && !fired; k++) begin
                sample_in = ($urandom_range(0, 2) == 0) ? trig_value : 8'($urandom);
                waddr = 4'($urandom);
                fire_exp = spec_match(sample_in) && (!trig_edge || !prev);
                prev = spec_match(sample_in);
                cyc();
                if (fire_exp) begin
                    fired = 1'b1;
                    exp_addr = waddr;
                    n_checks++; if (triggered !== 1'b1 || trig_addr !== exp_addr) begin n_fails++; $display("FAIL rnd_fire it=%0d got=%b/%0d exp=1/%0d", it, triggered, trig_addr, exp_addr); end
                end else begin
                    n_checks++; if (triggered !== 1'b0 || state !== 3'd2) begin n_fails++; $display("FAIL rnd_nofire it=%0d got=%b/%0d exp=0/2", it, triggered, state); end
                end
            end
            if (fired) begin
                post_count = 4'($urandom);
                wcnt = 0;
                for (int j = 0; j < 18 && !done; j++) begin
                    if (write_enable) wcnt++;
                    sample_in = 8'($urandom);
                    cyc();
                end
                n_checks++; if (wcnt != int'(pc)) begin n_fails++; $display("FAIL rnd_post it=%0d got=%0d exp=%0d", it, wcnt, pc); end
                n_checks++; if (done !== 1'b1 || state !== 3'd4 || write_enable !== 1'b0 || triggered !== 1'b1 || trig_addr !== exp_addr) begin n_fails++; $display("FAIL rnd_done it=%0d got=%b/%0d/%b/%b/%0d exp=1/4/0/1/%0d", it, done, state, write_enable, triggered, trig_addr, exp_addr); end
            end
            if (fired && $urandom_range(0, 1) == 1) begin
                arm = 1'b1;
                cyc();
                arm = 1'b0;
                in_fill = 1'b1;
            end else begin
                abort = 1'b1; arm = 1'($urandom);
                cyc();
                abort = 1'b0; arm = 1'b0;
                n_checks++; if (state !== 3'd0 || triggered !== 1'b0 || done !== 1'b0 || trig_addr !== exp_addr) begin n_fails++; $display("FAIL rnd_abort it=%0d got=%0d/%b/%b/%0d exp=0/0/0/%0d", it, state, triggered, done, trig_addr, exp_addr); end
                in_fill = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge_and_zero();
        test_abort_arm();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
